addr_gen_seq: RTL and testbench

ADDR_GEN_SEQ -- requirements
Module: addr_gen_seq

---
 rtl/addr_gen_pkg.sv | 14 +
 rtl/addr_gen_seq_addsub8.sv | 20 ++
 rtl/addr_gen_seq.sv | 121 ++++++++++++
 tb/tb_addr_gen_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_gen_pkg.sv
// rtl/addr_gen_pkg.sv - shared widths and FSM state encoding for addr_gen_seq
package addr_gen_pkg;

  localparam int PAGE_W = 8;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/addr_gen_seq_addsub8.sv
// rtl/addr_gen_seq_addsub8.sv - 8-bit adder/subtractor shared by the low and high byte passes
module addsub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  input  logic       add,
  output logic [7:0] s,
  output logic       co
);

  logic [7:0] b_eff;
  logic [8:0] sum;

  // Subtract is a + ~b + ci, so ci=1 means "no borrow in" and co=1 means "no borrow out".
  assign b_eff = add ? b : ~b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {8'b0, ci};
  assign s     = sum[7:0];
  assign co    = sum[8];

endmodule

// File: rtl/addr_gen_seq.sv
// rtl/addr_gen_seq.sv - two-pass effective address generator (low byte, optional high-byte fix-up)
// Optional feature: ADDR_GEN_SIGNED_OFFSET_EN treats offset as two's complement.
module addr_gen_seq
  import addr_gen_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] base,
  input  logic [PAGE_W-1:0] offset,
  input  logic              always_hi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              page_cross
);

`ifdef ADDR_GEN_SIGNED_OFFSET_EN
  localparam logic SIGNED_OFF = 1'b1;
`else
  localparam logic SIGNED_OFF = 1'b0;
`endif

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [PAGE_W-1:0] off_q;
  logic              hi_q;
  logic              carry_q;

  logic [PAGE_W-1:0] as_a;
  logic [PAGE_W-1:0] as_b;
  logic              as_ci;
  logic              as_add;
  logic [PAGE_W-1:0] as_s;
  logic              as_co;
  logic              neg_off;
  logic              cross_lo;

  assign neg_off = SIGNED_OFF & off_q[PAGE_W-1];

  // A negative offset crosses backward exactly when the low add produced no carry.
  assign cross_lo = neg_off ? ~as_co : as_co;

  always_comb begin
    as_a   = base_q[PAGE_W-1:0];
    as_b   = off_q;
    as_ci  = 1'b0;
    as_add = 1'b1;
    if (state == HI) begin
      as_a = base_q[ADDR_W-1:PAGE_W];
      as_b = '0;
      if (neg_off && !carry_q) begin
        as_add = 1'b0;
      end else if (!neg_off && carry_q) begin
        as_ci = 1'b1;
      end
    end
  end

  addsub8 u_addsub (
    .a   (as_a),
    .b   (as_b),
    .ci  (as_ci),
    .add (as_add),
    .s   (as_s),
    .co  (as_co)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      base_q     <= '0;
      off_q      <= '0;
      hi_q       <= 1'b0;
      carry_q    <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      addr       <= '0;
      page_cross <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            base_q   <= base;
            off_q    <= offset;
            hi_q     <= always_hi;
            in_ready <= 1'b0;
            state    <= LO;
          end
        end
        LO: begin
          addr[PAGE_W-1:0] <= as_s;
          carry_q          <= as_co;
          page_cross       <= cross_lo;
          if (cross_lo || hi_q) begin
            state <= HI;
          end else begin
            addr[ADDR_W-1:PAGE_W] <= base_q[ADDR_W-1:PAGE_W];
            out_valid             <= 1'b1;
            state                 <= DONE;
          end
        end
        HI: begin
          addr[ADDR_W-1:PAGE_W] <= as_s;
          out_valid             <= 1'b1;
          state                 <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_gen_seq.sv
// tb/tb_addr_gen_seq.sv - randomized and directed checks of addr_gen_seq against an arithmetic model
module tb_addr_gen_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] base;
  logic [7:0]  offset;
  logic        always_hi;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] addr;
  logic        page_cross;

  int total = 0;
  int bad   = 0;

  addr_gen_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .base       (base),
    .offset     (offset),
    .always_hi  (always_hi),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .addr       (addr),
    .page_cross (page_cross)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] eff_addr(input logic [15:0] b, input logic [7:0] o);
`ifdef ADDR_GEN_SIGNED_OFFSET_EN
    return b + {{8{o[7]}}, o};
`else
    return b + {8'h00, o};
`endif
  endfunction

  // Reference model: tracks only busy/valid timing and the arithmetic result.
  int          cyc = 0;
  bit          m_busy = 0;
  bit          m_valid = 0;
  int          m_valid_at = 0;
  logic [15:0] m_addr = '0;
  bit          m_pc = 0;
  int          acc_cnt = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  = 0;
      m_valid = 0;
    end else begin
      cyc++;
      if (m_valid && out_ready) begin
        m_busy  = 0;
        m_valid = 0;
      end else if (m_busy && !m_valid && cyc == m_valid_at) begin
        m_valid = 1;
      end else if (!m_busy && in_valid) begin
        m_addr     = eff_addr(base, offset);
        m_pc       = (m_addr[15:8] != base[15:8]);
        m_valid_at = cyc + ((m_pc || always_hi) ? 3 : 2) - 1;
        m_busy     = 1;
        acc_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk("addr", {16'b0, addr}, {16'b0, m_addr});
        chk("page_cross", {31'b0, page_cross}, {31'b0, m_pc});
      end
    end
  end

  bit rmode = 0;
  always @(negedge clk) if (rmode) out_ready = ($urandom_range(0, 3) != 0);

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (m_busy) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic run_dir(input string name, input logic [15:0] b, input logic [7:0] o,
                         input logic h, input logic [15:0] ea, input logic ep, input int el);
    int lat;
    wait_idle();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    base      = b;
    offset    = o;
    always_hi = h;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_addr"}, {16'b0, addr}, {16'b0, ea});
    chk({name, "_pc"}, {31'b0, page_cross}, {31'b0, ep});
    chk({name, "_lat"}, lat, el);
  endtask

  initial begin
    int n;
    int acc0;
    logic [15:0] hold_addr;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    base      = '0;
    offset    = '0;
    always_hi = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_addr", {16'b0, addr}, 0);
    chk("rst_pc", {31'b0, page_cross}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_dir("d_simple", 16'h1200, 8'h05, 1'b0, 16'h1205, 1'b0, 2);
    run_dir("d_cross", 16'h12F0, 8'h20, 1'b0, 16'h1310, 1'b1, 3);
    run_dir("d_wrap", 16'hFFF0, 8'h20, 1'b0, 16'h0010, 1'b1, 3);
    run_dir("d_force_hi", 16'h1200, 8'h05, 1'b1, 16'h1205, 1'b0, 3);
`ifdef ADDR_GEN_SIGNED_OFFSET_EN
    run_dir("d_neg_same", 16'h1205, 8'hFB, 1'b0, 16'h1200, 1'b0, 2);
    run_dir("d_neg_cross", 16'h1202, 8'hFB, 1'b0, 16'h11FD, 1'b1, 3);
    run_dir("d_neg_wrap", 16'h0002, 8'hFB, 1'b0, 16'hFFFD, 1'b1, 3);
`else
    run_dir("d_big_off", 16'h1205, 8'hFB, 1'b0, 16'h1300, 1'b1, 3);
    run_dir("d_no_carry", 16'h1202, 8'hFB, 1'b1, 16'h12FD, 1'b0, 3);
`endif

    // Consumer stall: result must hold and a new request must wait for the handshake.
    wait_idle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    base      = 16'h34F8;
    offset    = 8'h10;
    always_hi = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    hold_addr = addr;
    chk("hold_first", {16'b0, hold_addr}, 32'h3508);
    @(negedge clk);
    in_valid = 1'b1;
    base     = 16'h0101;
    offset   = 8'h01;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'b0, out_valid}, 1);
      chk("hold_addr", {16'b0, addr}, 32'h3508);
      chk("hold_pc", {31'b0, page_cross}, 1);
      chk("hold_ready", {31'b0, in_ready}, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    chk("hold_second_acc", {31'b0, in_ready}, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_second_addr", {16'b0, addr}, 32'h0102);

    // Asynchronous reset while in the high-byte pass.
    wait_idle();
    in_valid  = 1'b1;
    base      = 16'h12F0;
    offset    = 8'h20;
    always_hi = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'b0, in_ready}, 1);
    chk("arst_out_valid", {31'b0, out_valid}, 0);
    chk("arst_addr", {16'b0, addr}, 0);
    chk("arst_pc", {31'b0, page_cross}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("arst_no_pulse", {31'b0, out_valid}, 0);
    end

    // Randomized traffic with page-edge biasing and a random consumer.
    @(negedge clk);
    rmode = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      base      = 16'($urandom);
      offset    = 8'($urandom);
      always_hi = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: base[7:0] = 8'hF0 | 8'($urandom_range(0, 15));
        1: base[15:8] = 8'hFF;
        2: base[15:8] = 8'h00;
        default: ;
      endcase
      in_valid = 1'b1;
      acc0 = acc_cnt;
      n = 0;
      while (acc_cnt == acc0 && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (acc_cnt == acc0) chk("rand_accept_timeout", 1, 0);
      in_valid = 1'b0;
    end
    rmode = 0;
    out_ready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
